// File: rtl/fan_ctrl_pkg.sv
// Shared widths, field offsets and FSM encoding for the FAN configuration sequencer.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
// Descriptor layout: {rep, lvl[NUM_LEVEL-1] .. lvl[0]}, each lvl = NUM_NODE nodes,
// each node packed {add_en, bypass_en, sel[2*SEL_IN-1:0]}.
package fan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fsm_state_t;

    function automatic int node_w(input int sel_in);
        return 2 + 2 * sel_in;
    endfunction

    function automatic int lvl_w(input int num_node, input int sel_in);
        return num_node * node_w(sel_in);
    endfunction

    function automatic int cfg_w(input int num_level, input int num_node, input int sel_in);
        return num_level * lvl_w(num_node, sel_in);
    endfunction

    function automatic int desc_w(input int num_level, input int num_node, input int sel_in,
                                  input int cnt_w);
        return cfg_w(num_level, num_node, sel_in) + cnt_w;
    endfunction

    // Bit positions inside one node field.
    function automatic int add_en_ofs(input int sel_in);
        return 2 * sel_in + 1;
    endfunction

    function automatic int bypass_en_ofs(input int sel_in);
        return 2 * sel_in;
    endfunction

    // LSB of the repeat count inside a descriptor.
    function automatic int rep_ofs(input int num_level, input int num_node, input int sel_in);
        return cfg_w(num_level, num_node, sel_in);
    endfunction

endpackage

// File: rtl/fan_cfg_fifo.sv
// Descriptor buffer: synchronous FIFO of W bits x 2**AW entries with full/empty flags.
// Latency: pushed entry visible at pop_data the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; flush/reset empty it.
// Ports: clk, rst_n (sync, active-low), flush (sync clear), push/push_data,
//        pop/pop_data (show-ahead head entry), full, empty.
module fan_cfg_fifo #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    // count tops out at DEPTH, so its MSB alone marks full.
    assign full     = count[AW];
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fan_cfg_sequencer.sv
// FAN tree sequencer: buffers node-config descriptors and issues each to the tree for rep+1 vectors.
// Latency: first vec_ready 2 cycles after accept into empty IDLE; fire at t -> level k at t+1+k, out_valid t+1+NUM_LEVEL.
// Backpressure: cfg_ready drops when FIFO full or flushing; vec source gated by vec_ready; tree never stalls.
// Ports: clk, rst_n, flush; cfg_valid/cfg_ready/cfg_data (descriptor in); vec_valid/vec_ready (vector gate);
//        lvl_cfg/lvl_vld (per-level config + valid), out_valid (root), busy, cfg_err (sticky).
module fan_cfg_sequencer
    import fan_ctrl_pkg::*;
#(
    parameter int NUM_LEVEL = 3,
    parameter int NUM_NODE  = 4,
    parameter int SEL_IN    = 2,
    parameter int CNT_W     = 8,
    parameter int FIFO_AW   = 2
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic                                                 flush,
    input  logic                                                 cfg_valid,
    output logic                                                 cfg_ready,
    input  logic [desc_w(NUM_LEVEL, NUM_NODE, SEL_IN, CNT_W)-1:0] cfg_data,
    input  logic                                                 vec_valid,
    output logic                                                 vec_ready,
    output logic [cfg_w(NUM_LEVEL, NUM_NODE, SEL_IN)-1:0]         lvl_cfg,
    output logic [NUM_LEVEL-1:0]                                 lvl_vld,
    output logic                                                 out_valid,
    output logic                                                 busy,
    output logic                                                 cfg_err
);

    localparam int NODE_W  = node_w(SEL_IN);
    localparam int LVL_W   = lvl_w(NUM_NODE, SEL_IN);
    localparam int CFG_W   = cfg_w(NUM_LEVEL, NUM_NODE, SEL_IN);
    localparam int DESC_W  = desc_w(NUM_LEVEL, NUM_NODE, SEL_IN, CNT_W);
    localparam int ADD_OFS = add_en_ofs(SEL_IN);
    localparam int BYP_OFS = bypass_en_ofs(SEL_IN);
    localparam int REP_OFS = rep_ofs(NUM_LEVEL, NUM_NODE, SEL_IN);

    fsm_state_t        state;
    fsm_state_t        state_nxt;
    logic [CFG_W-1:0]  active_cfg;
    logic [CNT_W-1:0]  cnt;
    logic [DESC_W-1:0] fifo_din;
    logic [DESC_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              fire;
    logic              bad;
    logic [CFG_W-1:0]  san_cfg;
    logic [NODE_W-1:0] node;

    assign cfg_ready = rst_n & ~flush & ~fifo_full;
    assign push      = cfg_valid & cfg_ready;
    assign vec_ready = rst_n & ~flush & (state == RUN);
    assign fire      = vec_valid & vec_ready;
    assign busy      = (state != IDLE) | ~fifo_empty;

    // Contradictory nodes (add and bypass both requested) are neutralised before
    // they are stored, so the tree only ever sees legal configurations.
    always_comb begin
        san_cfg = cfg_data[CFG_W-1:0];
        bad     = 1'b0;
        node    = '0;
        for (int i = 0; i < NUM_LEVEL * NUM_NODE; i++) begin
            node = cfg_data[i*NODE_W +: NODE_W];
            if (node[ADD_OFS] && node[BYP_OFS]) begin
                bad           = 1'b1;
                node[ADD_OFS] = 1'b0;
                node[BYP_OFS] = 1'b0;
            end
            san_cfg[i*NODE_W +: NODE_W] = node;
        end
    end

    assign fifo_din = {cfg_data[REP_OFS +: CNT_W], san_cfg};

    fan_cfg_fifo #(
        .W  (DESC_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data (fifo_din),
        .pop       (pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A pop always loads the active register; in RUN it coincides with the last
    // fire of the previous descriptor so back-to-back descriptors have no bubble.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (fire && (cnt == '0)) begin
                    if (!fifo_empty) pop = 1'b1;
                    else             state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = RUN;
                end else if ((lvl_vld == '0) && !out_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state      <= IDLE;
            active_cfg <= '0;
            cnt        <= '0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                active_cfg <= fifo_dout[CFG_W-1:0];
                cnt        <= fifo_dout[REP_OFS +: CNT_W];
            end else if (fire && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Error flag survives flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n)          cfg_err <= 1'b0;
        else if (push && bad) cfg_err <= 1'b1;
    end

    // Triangular pipeline: stage g keeps slices g..NUM_LEVEL-1 of its vector's
    // config and hands the upper ones on, so each level sees the config of the
    // vector it currently holds. Idle stages carry all-zero config.
    for (genvar g = 0; g < NUM_LEVEL; g++) begin : g_stage
        localparam int SW = (NUM_LEVEL - g) * LVL_W;
        logic          vld_q;
        logic [SW-1:0] cfg_q;

        if (g == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (!rst_n || flush) begin
                    vld_q <= 1'b0;
                    cfg_q <= '0;
                end else begin
                    vld_q <= fire;
                    cfg_q <= fire ? active_cfg : '0;
                end
            end
        end else begin : g_tail
            always_ff @(posedge clk) begin
                if (!rst_n || flush) begin
                    vld_q <= 1'b0;
                    cfg_q <= '0;
                end else begin
                    vld_q <= g_stage[g-1].vld_q;
                    cfg_q <= g_stage[g-1].cfg_q[SW+LVL_W-1:LVL_W];
                end
            end
        end

        assign lvl_vld[g]               = vld_q;
        assign lvl_cfg[g*LVL_W +: LVL_W] = cfg_q[LVL_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) out_valid <= 1'b0;
        else                 out_valid <= g_stage[NUM_LEVEL-1].vld_q;
    end

endmodule
